// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types, default vectors and alignment helper for the
//               program-counter unit.
//               The PC_RVC_EN macro relaxes the alignment rule to 16 bits.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT  = 32'h0000_0100;

`ifdef PC_RVC_EN
  // Compressed instructions allow halfword-aligned targets.
  localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
  localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

  // True when the low target bits violate the instruction alignment.
  function automatic logic is_misaligned(input logic [1:0] target_lo);
    return (target_lo & ALIGN_MASK) != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational priority selection of next pc, next epc,
//               misaligned flag and next state for pc_unit.
//               PC_RVC_EN selects a 2-byte step when inst_len2 is set.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT)
) (
  input  pc_state_t         state_q,
  input  logic [XLEN-1:0]   pc_q,
  input  logic [XLEN-1:0]   epc_q,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap,
  input  logic              ret,
  input  logic              inst_len2,
  output logic [XLEN-1:0]   pc_plus,
  output logic [XLEN-1:0]   pc_d,
  output logic [XLEN-1:0]   epc_d,
  output pc_state_t         state_d,
  output logic              misaligned_d
);

`ifdef PC_RVC_EN
  assign pc_plus = pc_q + (inst_len2 ? XLEN'(2) : XLEN'(4));
`else
  // Instruction length is irrelevant without compressed support.
  logic unused_inst_len2;
  assign unused_inst_len2 = inst_len2;
  assign pc_plus = pc_q + XLEN'(4);
`endif

  // Priority mux: trap > ret > redirect > halt_req > stall > increment.
  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    state_d      = state_q;
    misaligned_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap) begin
          pc_d  = TRAP_VEC;
          epc_d = pc_q;
        end else if (ret) begin
          pc_d = epc_q;
        end else if (redirect) begin
          if (is_misaligned(redirect_target[1:0])) begin
            // A bad target is turned into a trap from the current pc.
            pc_d         = TRAP_VEC;
            epc_d        = pc_q;
            misaligned_d = 1'b1;
          end else begin
            pc_d = redirect_target;
          end
        end else if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          pc_d = pc_plus;
        end
      end
      HALT: begin
        if (resume) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : XLEN-wide program counter with boot/run/halt control,
//               branch redirect, trap entry/return and misalignment trap.
//               Optional macro PC_RVC_EN enables 16-bit instruction support.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap,
  input  logic              ret,
  input  logic              inst_len2,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus,
  output logic              pc_valid,
  output logic [XLEN-1:0]   epc,
  output logic              misaligned,
  output logic              halted
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misaligned_q, misaligned_d;

  pc_next_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_sel (
    .state_q         (state_q),
    .pc_q            (pc_q),
    .epc_q           (epc_q),
    .stall           (stall),
    .halt_req        (halt_req),
    .resume          (resume),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .trap            (trap),
    .ret             (ret),
    .inst_len2       (inst_len2),
    .pc_plus         (pc_plus),
    .pc_d            (pc_d),
    .epc_d           (epc_d),
    .state_d         (state_d),
    .misaligned_d    (misaligned_d)
  );

  // State and PC registers; reset returns to BOOT at the reset vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign misaligned = misaligned_q;
  assign pc_valid   = (state_q == RUN);
  assign halted     = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

`ifdef PC_RVC_EN
  localparam bit          RVC   = 1'b1;
  localparam logic [31:0] MIS_T = 32'h0000_0203;
`else
  localparam bit          RVC   = 1'b0;
  localparam logic [31:0] MIS_T = 32'h0000_0202;
`endif
  localparam logic [31:0] L2_STEP = RVC ? 32'd2 : 32'd4;

  // Control bit order: {stall, halt_req, resume, redirect, trap, ret, len2}
  localparam logic [6:0] C_0 = 7'b0000000;
  localparam logic [6:0] C_S = 7'b1000000;
  localparam logic [6:0] C_H = 7'b0100000;
  localparam logic [6:0] C_R = 7'b0010000;
  localparam logic [6:0] C_D = 7'b0001000;
  localparam logic [6:0] C_T = 7'b0000100;
  localparam logic [6:0] C_E = 7'b0000010;
  localparam logic [6:0] C_L = 7'b0000001;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_epc;
    logic        e_mis;
    logic        e_halted;
  } vec_t;

  logic        clk, reset, stall, halt_req, resume, redirect, trap, ret, inst_len2;
  logic [31:0] redirect_target, pc, pc_plus, epc;
  logic        pc_valid, misaligned, halted;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_pc;
  vec_t        exp_q[$];
  vec_t        tbl[32];

  pc_unit #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_1000),
    .TRAP_VEC  (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .halt_req        (halt_req),
    .resume          (resume),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .trap            (trap),
    .ret             (ret),
    .inst_len2       (inst_len2),
    .pc              (pc),
    .pc_plus         (pc_plus),
    .pc_valid        (pc_valid),
    .epc             (epc),
    .misaligned      (misaligned),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] tgt,
                              input logic [31:0] e_pc, input logic e_valid,
                              input logic [31:0] e_epc, input logic e_mis,
                              input logic e_halted);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.e_pc = e_pc; v.e_valid = e_valid;
    v.e_epc = e_epc; v.e_mis = e_mis; v.e_halted = e_halted;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [6:0] ctl, input logic [31:0] tgt);
    {stall, halt_req, resume, redirect, trap, ret, inst_len2} = ctl;
    redirect_target = tgt;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    drive(v.ctl, v.tgt);
    exp_q.push_back(v);
    #1;
    check("pc_plus", pc_plus, cur_pc + ((RVC && v.ctl[0]) ? 32'd2 : 32'd4));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pc", pc, e.e_pc);
    check("pc_valid", 32'(pc_valid), 32'(e.e_valid));
    check("epc", epc, e.e_epc);
    check("misaligned", 32'(misaligned), 32'(e.e_mis));
    check("halted", 32'(halted), 32'(e.e_halted));
    cur_pc = e.e_pc;
  endtask

  initial begin
    tbl[0]  = mk(C_H|C_T|C_D|C_S, 32'h900, 32'h1000, 1, 0, 0, 0);
    tbl[1]  = mk(C_0, 0, 32'h1004, 1, 0, 0, 0);
    tbl[2]  = mk(C_0, 0, 32'h1008, 1, 0, 0, 0);
    tbl[3]  = mk(C_D, 32'h20, 32'h20, 1, 0, 0, 0);
    tbl[4]  = mk(C_S, 0, 32'h20, 1, 0, 0, 0);
    tbl[5]  = mk(C_S, 0, 32'h20, 1, 0, 0, 0);
    tbl[6]  = mk(C_S, 0, 32'h20, 1, 0, 0, 0);
    tbl[7]  = mk(C_0, 0, 32'h24, 1, 0, 0, 0);
    tbl[8]  = mk(C_D, 32'h40, 32'h40, 1, 0, 0, 0);
    tbl[9]  = mk(C_D, 32'h200, 32'h200, 1, 0, 0, 0);
    tbl[10] = mk(C_D, 32'h40, 32'h40, 1, 0, 0, 0);
    tbl[11] = mk(C_D, MIS_T, 32'h100, 1, 32'h40, 1, 0);
    tbl[12] = mk(C_0, 0, 32'h104, 1, 32'h40, 0, 0);
    tbl[13] = mk(C_D, 32'h80, 32'h80, 1, 32'h40, 0, 0);
    tbl[14] = mk(C_T|C_D|C_S, 32'h300, 32'h100, 1, 32'h80, 0, 0);
    tbl[15] = mk(C_0, 0, 32'h104, 1, 32'h80, 0, 0);
    tbl[16] = mk(C_E, 0, 32'h80, 1, 32'h80, 0, 0);
    tbl[17] = mk(C_E|C_D, 32'h400, 32'h80, 1, 32'h80, 0, 0);
    tbl[18] = mk(C_T|C_E, 0, 32'h100, 1, 32'h80, 0, 0);
    tbl[19] = mk(C_D|C_S|C_H, 32'h10, 32'h10, 1, 32'h80, 0, 0);
    tbl[20] = mk(C_H|C_S, 0, 32'h10, 0, 32'h80, 0, 1);
    tbl[21] = mk(C_D|C_T, 32'h500, 32'h10, 0, 32'h80, 0, 1);
    tbl[22] = mk(C_T|C_H|C_E|C_S, 0, 32'h10, 0, 32'h80, 0, 1);
    tbl[23] = mk(C_R, 0, 32'h10, 1, 32'h80, 0, 0);
    tbl[24] = mk(C_0, 0, 32'h14, 1, 32'h80, 0, 0);
    tbl[25] = mk(C_D, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h80, 0, 0);
    tbl[26] = mk(C_0, 0, 32'h0, 1, 32'h80, 0, 0);
    tbl[27] = mk(C_L, 0, L2_STEP, 1, 32'h80, 0, 0);
    tbl[28] = mk(C_D, 32'h1, 32'h100, 1, L2_STEP, 1, 0);
    tbl[29] = mk(C_H, 0, 32'h100, 0, L2_STEP, 0, 1);
    tbl[30] = mk(C_R|C_D|C_T, 32'h700, 32'h100, 1, L2_STEP, 0, 0);
    tbl[31] = mk(C_0, 0, 32'h104, 1, L2_STEP, 0, 0);

    // Power-on reset
    reset = 1'b1;
    drive(C_0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h1000);
    check("rst_valid", 32'(pc_valid), 32'd0);
    check("rst_epc", epc, 32'h0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    #1;
    check("boot_pc", pc, 32'h1000);
    check("boot_valid", 32'(pc_valid), 32'd0);
    cur_pc = 32'h1000;

    for (int i = 0; i < 32; i++) step(tbl[i]);

    // Reset asserted in the middle of HALT
    step(mk(C_H, 0, 32'h104, 0, L2_STEP, 0, 1));
    #3;
    reset = 1'b1;
    #1;
    check("hrst_pc", pc, 32'h1000);
    check("hrst_valid", 32'(pc_valid), 32'd0);
    check("hrst_halted", 32'(halted), 32'd0);
    check("hrst_epc", epc, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("hrst_boot_pc", pc, 32'h1000);
    check("hrst_boot_valid", 32'(pc_valid), 32'd0);
    cur_pc = 32'h1000;
    step(mk(C_0, 0, 32'h1000, 1, 0, 0, 0));
    step(mk(C_0, 0, 32'h1004, 1, 0, 0, 0));

`ifdef PC_RVC_EN
    // Compressed stepping and halfword-aligned redirect
    step(mk(C_D, 32'h0, 32'h0, 1, 0, 0, 0));
    step(mk(C_L, 0, 32'h2, 1, 0, 0, 0));
    step(mk(C_D, 32'h6, 32'h6, 1, 0, 0, 0));
    step(mk(C_D, 32'h3, 32'h100, 1, 32'h6, 1, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core front end. It replaces the plain PC register with an XLEN-wide, reset-vector-configurable PC. The unit adds a boot state, stall/halt control, branch redirect, trap entry/return with a saved exception PC, and misaligned-target detection. It sits between the next-PC logic of the execute stage and instruction fetch.

## Interface
- XLEN, 32, PC/target width in bits
- RESET_VEC, 32'h0000_0000, PC value loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC this cycle
- halt_req  in  1  enter HALT state
- resume  in  1  leave HALT state
- redirect  in  1  branch/jump taken
- redirect_target  in  XLEN  branch/jump destination
- trap  in  1  exception/ecall entry
- ret  in  1  return from trap to epc
- inst_len2  in  1  current instruction is 16-bit (used only with PC_RVC_EN)
- pc  out  XLEN  current fetch PC (registered)
- pc_plus  out  XLEN  sequential next PC (combinational from pc)
- pc_valid  out  1  pc is a valid fetch address
- epc  out  XLEN  PC saved at trap entry
- misaligned  out  1  one-cycle pulse: misaligned redirect converted to trap
- halted  out  1  state == HALT

## Operation
- States: BOOT, RUN, HALT.
- Reset (async, any cycle, including mid-operation): state=BOOT, pc=RESET_VEC, pc_valid=0, epc=0, misaligned=0, halted=0.
- BOOT: one cycle. pc holds RESET_VEC. Next edge → RUN with pc_valid=1, pc unchanged. All control inputs are ignored in BOOT.
- RUN update priority, highest first:
  - trap: pc←TRAP_VEC, epc←pc.
  - ret: pc←epc.
  - redirect, aligned: pc←redirect_target.
  - redirect, misaligned: pc←TRAP_VEC, epc←pc, misaligned=1 for one cycle.
  - halt_req: state←HALT, pc held.
  - stall: pc held.
  - otherwise: pc←pc_plus.
- A lower-priority input is ignored in any cycle where a higher one is active. Example: trap+redirect+stall together → trap taken.
- HALT: pc held, pc_valid=0, halted=1. All inputs except resume are ignored. resume → RUN, pc_valid=1, same pc.
- Arithmetic: pc_plus = pc+4 (or pc+2, see Configuration), modulo 2^XLEN. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Alignment rule: target[1:0]!=0 is misaligned.

## Timing
- All outputs except pc_plus are registered and update on the rising clk edge after the input cycle. Latency is 1 cycle.
- pc_plus tracks pc combinationally within the same cycle.
- misaligned is high exactly one cycle: the cycle in which pc==TRAP_VEC first appears.
- stall held for N cycles holds pc for N cycles; increment resumes on the first cycle stall is low.

## Configuration
- PC_RVC_EN defined:
  - pc_plus = pc + (inst_len2 ? 2 : 4).
  - Alignment rule relaxes to target[0]!=0 is misaligned.
- PC_RVC_EN undefined:
  - inst_len2 is ignored and pc_plus = pc+4.
  - target[1:0]!=0 is misaligned.

## Structure
- Shared package pc_pkg holds:
  - the state enum pc_state_t {BOOT, RUN, HALT};
  - localparam defaults for RESET_VEC and TRAP_VEC;
  - a function is_misaligned(target).
- One sub-module, pc_next_sel: combinational priority mux producing next pc, next epc, misaligned and next state.
- pc_unit keeps only the registers and the state machine.

## Test plan
- Reset with RESET_VEC=32'h1000, release, no other inputs → pc=32'h1000 for 2 cycles (pc_valid 0 then 1), then 32'h1004, 32'h1008.
- In RUN at pc=32'h20: stall high 3 cycles → pc stays 32'h20 for 3 cycles, then 32'h24.
- At pc=32'h40: redirect=1, target=32'h200 → pc=32'h200 next cycle. Repeat with target=32'h202 (no RVC) → pc=TRAP_VEC, epc=32'h40, misaligned pulses 1 cycle.
- At pc=32'h80: trap+redirect+stall together → pc=32'h100, epc=32'h80. Later ret → pc=32'h80.
- halt_req at pc=32'h10 → halted=1, pc_valid=0, pc frozen while redirect/trap toggle. resume → pc_valid=1, pc=32'h10, then 32'h14. Assert reset mid-HALT → pc=RESET_VEC, state BOOT.
- With PC_RVC_EN: pc=32'h0, inst_len2=1 → 32'h2. Redirect to 32'h6 is accepted. At pc=32'hFFFF_FFFC with inst_len2=0 → pc wraps to 0.
